// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: FSM state encoding and frame constants shared by the boot loader.
package imem_loader_pkg;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN0 = 3'd1,
      S_LEN1 = 3'd2,
      S_DATA = 3'd3,
      S_CHK  = 3'd4,
      S_DONE = 3'd5,
      S_ERR  = 3'd6
   } state_t;
   localparam int LEN_BYTES = 2;
   localparam int CHK_BYTES = 1;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles little-endian words from bytes, keeps the running XOR and a registered write strobe.
module imem_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word,
   output logic [7:0]  xor_acc,
   output logic [1:0]  lane
);
   logic [23:0] asm_r;
   always_ff @(posedge clk) begin
      if (reset) begin
         lane       <= '0;
         asm_r      <= '0;
         xor_acc    <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= byte_en && lane == 2'd3;
         if (clear) begin
            lane    <= '0;
            xor_acc <= '0;
         end else if (byte_en) begin
            lane    <= lane + 2'd1;
            xor_acc <= xor_acc ^ byte_data;
            // the top byte goes straight into the output word; lower lanes wait in asm_r
            if (lane == 2'd3) word <= {byte_data, asm_r};
            else asm_r[{lane, 3'b000} +: 8] <= byte_data;
         end
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer that loads a length/words/checksum byte stream into instruction memory.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ROM_size = 1024,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);
   state_t      state, state_n;
   logic [15:0] len, n_full;
   logic [1:0]  lane;
   logic [7:0]  xor_acc;
   logic        word_valid, accept, pack_en, clear, last_word;
   assign byte_ready = state inside {S_LEN0, S_LEN1, S_DATA, S_CHK};
   assign accept     = byte_valid && byte_ready;
   assign pack_en    = accept && state == S_DATA;
   assign clear      = start && (state inside {S_IDLE, S_DONE, S_ERR});
   assign n_full     = {byte_data, len[7:0]};
   assign last_word  = (16'(words_loaded) + 16'd1) == len;
   assign done       = state == S_DONE;
   assign error      = state == S_ERR;
   assign cpu_hold   = state != S_DONE;
   // reset must suppress a write already in flight
   assign imem_we    = word_valid && !reset;
   imem_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .byte_en    (pack_en),
      .byte_data  (byte_data),
      .word_valid (word_valid),
      .word       (imem_wdata),
      .xor_acc    (xor_acc),
      .lane       (lane)
   );
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) state_n = S_LEN0;
         S_LEN0: if (byte_valid) state_n = S_LEN1;
         S_LEN1: if (byte_valid) state_n = (32'(n_full) > ROM_size) ? S_ERR : (n_full == 16'd0) ? S_CHK : S_DATA;
         S_DATA: if (byte_valid && lane == 2'd3 && last_word) state_n = S_CHK;
         S_CHK:  if (byte_valid) state_n = (byte_data == xor_acc) ? S_DONE : S_ERR;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         len          <= '0;
         words_loaded <= '0;
         imem_addr    <= '0;
      end else begin
         state <= state_n;
         if (clear) begin
            len          <= '0;
            words_loaded <= '0;
         end
         if (accept && state == S_LEN0) len[7:0] <= byte_data;
         if (accept && state == S_LEN1) len[15:8] <= byte_data;
         // count and address are captured with the 4th byte so both are valid in the write cycle
         if (pack_en && lane == 2'd3) begin
            words_loaded <= words_loaded + 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames checked against a byte-index model of the loader every cycle.
module tb_imem_loader;
   localparam int ROM = 1024;
   localparam int AW  = 10;
   typedef logic [7:0] bq_t[$];
   logic          clk = 1'b0;
   logic          reset, start, byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready, imem_we, cpu_hold, done, error;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   words_loaded;
   int            n_chk = 0, n_fail = 0;
   int            wlog_a[$];
   logic [31:0]   wlog_d[$];
   int            m_st = 0, m_k = 0, m_n = 0, m_addr = 0, m_loaded = 0, p;
   logic [7:0]    m_x = 8'h00;
   logic [31:0]   m_word = 0, m_wdata = 0;
   bit            m_we = 0, m_ready = 0;
   bq_t           f1, fp;

   imem_loader #(.ROM_size(ROM), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // model: states 0 idle, 1 loading, 2 done, 3 error; m_k counts accepted frame bytes
   initial forever begin
      @(posedge clk);
      #1;
      m_we = 0;
      if (reset) begin
         m_st = 0; m_loaded = 0; m_addr = 0; m_wdata = 0;
      end else if (start && m_st != 1) begin
         m_st = 1; m_k = 0; m_x = 0; m_loaded = 0;
      end else if (byte_valid && m_ready) begin
         if (m_k == 0) m_n = int'(byte_data);
         else if (m_k == 1) begin
            m_n += int'(byte_data) * 256;
            if (m_n > ROM) m_st = 3;
         end else if (m_k < 2 + 4 * m_n) begin
            p = m_k - 2;
            m_x ^= byte_data;
            m_word = (p % 4 == 0) ? 32'(byte_data) : m_word | (32'(byte_data) << (8 * (p % 4)));
            if (p % 4 == 3) begin
               m_we = 1; m_addr = p / 4; m_wdata = m_word; m_loaded++;
            end
         end else m_st = (byte_data == m_x) ? 2 : 3;
         m_k++;
      end
      m_ready = m_st == 1;
      chk("byte_ready", byte_ready, m_ready);
      chk("imem_we", imem_we, m_we);
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, m_wdata);
      chk("done", done, m_st == 2);
      chk("error", error, m_st == 3);
      chk("cpu_hold", cpu_hold, m_st != 2);
      chk("words_loaded", words_loaded, m_loaded);
      if (imem_we === 1'b1) begin
         wlog_a.push_back(int'(imem_addr));
         wlog_d.push_back(imem_wdata);
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input bq_t f, input bit gap);
      int t;
      foreach (f[i]) begin
         if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
         end
         byte_valid = 1'b1;
         byte_data  = f[i];
         t = 0;
         while (!byte_ready && t < 20) begin
            t++;
            @(negedge clk);
         end
         if (!byte_ready) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: byte %0d never accepted", i);
         end
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      f1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst cpu_hold", cpu_hold, 1);
      chk("rst done", done, 0);
      chk("rst wdata", imem_wdata, 0);
      // nominal two-word image
      do_start(); send(f1, 0); repeat (2) @(negedge clk);
      chk("s1 done", done, 1);
      chk("s1 cpu_hold", cpu_hold, 0);
      chk("s1 words", words_loaded, 2);
      chk("s1 nwrites", wlog_a.size(), 2);
      chk("s1 a0", wlog_a[0], 0);
      chk("s1 d0", wlog_d[0], 32'h13);
      chk("s1 a1", wlog_a[1], 1);
      chk("s1 d1", wlog_d[1], 32'h6F);
      // bad checksum
      fp = f1; fp[10] = 8'h00;
      do_start(); send(fp, 0); repeat (2) @(negedge clk);
      chk("s2 error", error, 1);
      chk("s2 done", done, 0);
      chk("s2 cpu_hold", cpu_hold, 1);
      chk("s2 nwrites", wlog_a.size(), 4);
      // length overflow N=1025
      do_start(); send('{8'h01, 8'h04}, 0); repeat (3) @(negedge clk);
      chk("s3 error", error, 1);
      chk("s3 byte_ready", byte_ready, 0);
      chk("s3 nwrites", wlog_a.size(), 4);
      // empty image, good then bad checksum
      do_start(); send('{8'h00, 8'h00, 8'h00}, 0); repeat (2) @(negedge clk);
      chk("s4 done", done, 1);
      do_start(); send('{8'h00, 8'h00, 8'h55}, 0); repeat (2) @(negedge clk);
      chk("s4 error", error, 1);
      chk("s4 nwrites", wlog_a.size(), 4);
      // throttled source
      do_start(); send(f1, 1); repeat (2) @(negedge clk);
      chk("s5 done", done, 1);
      chk("s5 nwrites", wlog_a.size(), 6);
      chk("s5 d0", wlog_d[4], 32'h13);
      chk("s5 d1", wlog_d[5], 32'h6F);
      // reset after 6 data bytes, then a clean reload
      fp = f1[0:7];
      do_start(); send(fp, 0);
      reset = 1'b1;
      #1 chk("s6 rst we", imem_we, 0);
      @(negedge clk);
      reset = 1'b0;
      chk("s6 words", words_loaded, 0);
      chk("s6 addr", imem_addr, 0);
      chk("s6 cpu_hold", cpu_hold, 1);
      do_start(); send(f1, 0); repeat (2) @(negedge clk);
      chk("s6 done", done, 1);
      chk("s6 nwrites", wlog_a.size(), 9);
      chk("s6 a0", wlog_a[7], 0);
      chk("s6 d1", wlog_d[8], 32'h6F);
      // reset while a write is pending must suppress it
      fp = f1[0:5];
      do_start(); send(fp, 0);
      chk("s7 pending", imem_we, 1);
      reset = 1'b1;
      #1 chk("s7 rst we", imem_we, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("s7 words", words_loaded, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
